// File: rtl/serial_mag_comparator_if.sv
// Handshake and bit-cell bundle between the controlling logic and the
// bit-serial magnitude comparator.
interface serial_mag_comparator_if;
  logic start;
  logic bit_valid;
  logic lt_in;
  logic eq_in;
  logic gt_in;
  logic busy;
  logic done;
  logic L;
  logic E;
  logic G;
  logic err;

  modport master (
    output start, bit_valid, lt_in, eq_in, gt_in,
    input  busy, done, L, E, G, err
  );

  modport slave (
    input  start, bit_valid, lt_in, eq_in, gt_in,
    output busy, done, L, E, G, err
  );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: folds per-bit L/E/G cell outputs, MSB first,
// into a WIDTH-bit L/E/G result with a start/busy/done handshake.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  serial_mag_comparator_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic          decided_q;
  logic          resGt_q;
  logic          busy_q;
  logic          done_q;
  logic          l_q;
  logic          e_q;
  logic          g_q;
  logic          err_q;

  logic          oneHot;
  logic          decideNow;
  logic          decided_d;
  logic          resGt_d;
  logic [CW-1:0] count_d;
  logic          lastBit;

  // Malformed cell outputs count as "equal", so only a clean lt/gt can decide.
  assign oneHot    = ({bus.lt_in, bus.eq_in, bus.gt_in} == 3'b100) ||
                     ({bus.lt_in, bus.eq_in, bus.gt_in} == 3'b010) ||
                     ({bus.lt_in, bus.eq_in, bus.gt_in} == 3'b001);
  assign decideNow = !decided_q && oneHot && (bus.lt_in || bus.gt_in);
  assign decided_d = decided_q || decideNow;
  assign resGt_d   = decided_q ? resGt_q : bus.gt_in;
  assign count_d   = count_q + CW'(1);
  assign lastBit   = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      decided_q <= 1'b0;
      resGt_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      l_q       <= 1'b0;
      e_q       <= 1'b0;
      g_q       <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            count_q   <= '0;
            decided_q <= 1'b0;
            resGt_q   <= 1'b0;
            l_q       <= 1'b0;
            e_q       <= 1'b0;
            g_q       <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        RUN: begin
          if (bus.bit_valid) begin
            count_q   <= count_d;
            decided_q <= decided_d;
            resGt_q   <= resGt_d;
            if (!oneHot) begin
              err_q <= 1'b1;
            end
            // Result is published on the same edge that takes the last bit.
            if (lastBit) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              l_q     <= decided_d && !resGt_d;
              g_q     <= decided_d && resGt_d;
              e_q     <= !decided_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.L    = l_q;
  assign bus.E    = e_q;
  assign bus.G    = g_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed bench for serial_mag_comparator at WIDTH=4: a table of full
// comparisons plus hand-written gap, restart-attempt and reset-abort sequences.
module tb_serial_mag_comparator;

  typedef struct {
    string      name;
    logic [11:0] bits;
    logic [3:0]  expLegErr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;
  vec_t vecs[7];

  serial_mag_comparator_if bus ();

  serial_mag_comparator #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setBit(input logic valid, input logic [2:0] triple);
    bus.bit_valid = valid;
    {bus.lt_in, bus.eq_in, bus.gt_in} = triple;
  endtask

  task automatic applyStimulus(input string tag, input logic [11:0] bits,
                               input logic [3:0] expLegErr);
    bus.start = 1'b1;
    setBit(1'b0, 3'b000);
    stepCycle();
    bus.start = 1'b0;
    checkOutput({tag, " busy/done after start"}, {6'd0, bus.busy, bus.done}, 8'h02);
    checkOutput({tag, " cleared LEG/err"}, {4'd0, bus.L, bus.E, bus.G, bus.err}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      setBit(1'b1, bits[11-3*i -: 3]);
      stepCycle();
      if (i < 3) begin
        checkOutput({tag, " busy/done mid"}, {6'd0, bus.busy, bus.done}, 8'h02);
      end else begin
        checkOutput({tag, " busy/done at end"}, {6'd0, bus.busy, bus.done}, 8'h01);
      end
    end
    setBit(1'b0, 3'b000);
    checkOutput({tag, " result"}, {4'd0, bus.L, bus.E, bus.G, bus.err}, {4'd0, expLegErr});
    stepCycle();
    checkOutput({tag, " done dropped"}, {6'd0, bus.busy, bus.done}, 8'h00);
    checkOutput({tag, " result held"}, {4'd0, bus.L, bus.E, bus.G, bus.err}, {4'd0, expLegErr});
  endtask

  initial begin
    // triples are {lt,eq,gt}, MSB first; expected is {L,E,G,err}
    vecs[0] = '{"1010v1001", {3'b010, 3'b010, 3'b001, 3'b100}, 4'b0010};
    vecs[1] = '{"0110v0110", {3'b010, 3'b010, 3'b010, 3'b010}, 4'b0100};
    vecs[2] = '{"0011v1000", {3'b100, 3'b010, 3'b001, 3'b001}, 4'b1000};
    vecs[3] = '{"0101 illegal", {3'b010, 3'b011, 3'b010, 3'b010}, 4'b0101};
    vecs[4] = '{"0001v0000", {3'b010, 3'b010, 3'b010, 3'b001}, 4'b0010};
    vecs[5] = '{"illegal after L", {3'b100, 3'b111, 3'b010, 3'b000}, 4'b1001};
    vecs[6] = '{"000 then G", {3'b000, 3'b001, 3'b100, 3'b010}, 4'b0011};

    bus.start = 1'b0;
    setBit(1'b0, 3'b000);
    #12;
    checkOutput("reset asserted", {2'd0, bus.busy, bus.done, bus.L, bus.E, bus.G, bus.err}, 8'h00);
    rst = 1'b0;
    stepCycle();
    for (int c = 0; c < 10; c++) begin
      checkOutput("idle after reset", {2'd0, bus.busy, bus.done, bus.L, bus.E, bus.G, bus.err}, 8'h00);
      stepCycle();
    end

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].name, vecs[v].bits, vecs[v].expLegErr);
    end

    // Gapped valid strobes: bits land on cycles 1, 3, 4 and 7 after start.
    bus.start = 1'b1;
    stepCycle();
    bus.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      setBit((c == 1 || c == 3 || c == 4 || c == 7), 3'b010);
      stepCycle();
      if (c < 7) begin
        checkOutput("gap still running", {5'd0, bus.busy, bus.done, bus.E}, 8'h04);
      end
    end
    setBit(1'b0, 3'b000);
    checkOutput("gap result", {3'd0, bus.busy, bus.done, bus.L, bus.E, bus.G}, 8'h0A);
    stepCycle();

    // Start with a coincident gt bit, then start re-asserted while running.
    bus.start = 1'b1;
    setBit(1'b1, 3'b001);
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      bus.start = (i < 2);
      setBit(1'b1, (i == 0) ? 3'b100 : ((i == 3) ? 3'b001 : 3'b010));
      stepCycle();
      if (i < 3) begin
        checkOutput("no restart busy", {6'd0, bus.busy, bus.done}, 8'h02);
      end
    end
    bus.start = 1'b1;
    setBit(1'b1, 3'b001);
    checkOutput("no restart result", {3'd0, bus.busy, bus.done, bus.L, bus.E, bus.G}, 8'h0C);
    stepCycle();
    bus.start = 1'b0;
    setBit(1'b0, 3'b000);
    checkOutput("start in DONE ignored", {5'd0, bus.busy, bus.done, bus.L}, 8'h01);
    stepCycle();
    checkOutput("still idle", {6'd0, bus.busy, bus.done}, 8'h00);

    // Abort after two bits that would have decided G with an error flagged.
    bus.start = 1'b1;
    stepCycle();
    bus.start = 1'b0;
    setBit(1'b1, 3'b111);
    stepCycle();
    setBit(1'b1, 3'b001);
    stepCycle();
    setBit(1'b0, 3'b000);
    checkOutput("pre-abort busy/err", {6'd0, bus.busy, bus.err}, 8'h03);
    #3 rst = 1'b1;
    #1;
    checkOutput("async reset clears", {2'd0, bus.busy, bus.done, bus.L, bus.E, bus.G, bus.err}, 8'h00);
    #2 rst = 1'b0;
    stepCycle();
    applyStimulus("after abort", {3'b010, 3'b010, 3'b100, 3'b010}, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
